// File: rtl/track_scheduler_pkg.sv
// Shared types and constants for the multi-track SD block scheduler.
// Address layout: track number in the upper bits, 512-byte block index below.
package track_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned CHAN_SHIFT  = 25;
  localparam int unsigned BLOCK_BYTES = 512;

  function automatic logic [31:0] block_addr(input logic [31:0] chan, input logic [31:0] ptr);
    return (chan << CHAN_SHIFT) + (ptr * BLOCK_BYTES);
  endfunction

endpackage

// File: rtl/track_scheduler_rr_arbiter.sv
// Combinational round-robin picker: searches upward from one past the
// last-served index and returns a one-hot grant (all-zero if no request).
module rr_arbiter #(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic [CHANNELS-1:0] i_req,
  input  logic [IDX_W-1:0]    i_last,
  output logic [CHANNELS-1:0] o_grant
);

  logic             w_found;
  logic [IDX_W-1:0] w_idx;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned off = 1; off <= CHANNELS; off++) begin
      w_idx = IDX_W'((32'(i_last) + off) % CHANNELS);
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/track_scheduler.sv
// Arbitrates one record stream and CHANNELS playback tracks onto a single
// SD store/load engine, tracking a per-track block pointer for each.
module track_scheduler
  import track_sched_pkg::*;
#(
  parameter int unsigned WORD_WIDTH     = 8,
  parameter int unsigned CHANNELS       = 8,
  parameter int unsigned TRACK_BLOCKS   = 65536,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  localparam int unsigned CHAN_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                rewind,
  input  logic                rec_req,
  input  logic [CHAN_W-1:0]   rec_chan,
  input  logic [CHANNELS-1:0] play_req,
  input  logic [CHANNELS-1:0] play_en,
  output logic                op_store,
  output logic                op_load,
  output logic [31:0]         op_addr,
  output logic [CHAN_W-1:0]   op_chan,
  input  logic                op_done,
  output logic                rec_grant,
  output logic [CHANNELS-1:0] play_grant,
  output logic                busy,
  output logic                timeout_err
);

  localparam int unsigned PTR_W = (TRACK_BLOCKS > 1) ? $clog2(TRACK_BLOCKS) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(TRACK_BLOCKS - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CHAN_W-1:0] CHAN_LAST = CHAN_W'(CHANNELS - 1);

  if (WORD_WIDTH == 0) begin : g_word_width_unsupported
  end

  state_t r_state, w_next;

  logic                r_is_rec;
  logic [CHAN_W-1:0]   r_op_chan;
  logic [31:0]         r_op_addr;
  logic [CHAN_W-1:0]   r_last;
  logic [PTR_W-1:0]    r_rec_ptr;
  logic [PTR_W-1:0]    r_play_ptr [CHANNELS];
  logic [CHAN_W-1:0]   r_rec_chan_prev;
  logic                r_rewound;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_timeout_err;

  logic [CHANNELS-1:0] w_elig;
  logic [CHANNELS-1:0] w_rr_gnt;
  logic [CHAN_W-1:0]   w_play_idx;
  logic                w_start;
  logic                w_rec_chg;
  logic                w_wait_expired;
  logic                w_do_inc;
  logic [CHAN_W-1:0]   w_sel_chan;
  logic [PTR_W-1:0]    w_sel_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign w_elig         = play_req & play_en;
  assign w_start        = enable && (rec_req || (|w_elig));
  assign w_rec_chg      = (rec_chan != r_rec_chan_prev);
  assign w_wait_expired = (r_state == WAIT) && !op_done && (r_cnt == CNT_LAST);
  // A rewind seen while the transaction was in flight (or in DONE itself)
  // means the completed block must not advance the freshly cleared pointer.
  assign w_do_inc       = (r_state == DONE) && !r_rewound && !rewind;

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .IDX_W    (CHAN_W)
  ) u_rr (
    .i_req   (w_elig),
    .i_last  (r_last),
    .o_grant (w_rr_gnt)
  );

  always_comb begin
    w_play_idx = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (w_rr_gnt[i]) w_play_idx = CHAN_W'(i);
    end
  end

  // Pointer clears that land on the latch cycle are reflected in the address.
  always_comb begin
    if (rec_req) begin
      w_sel_chan = rec_chan;
      w_sel_ptr  = (rewind || w_rec_chg) ? '0 : r_rec_ptr;
    end else begin
      w_sel_chan = w_play_idx;
      w_sel_ptr  = rewind ? '0 : r_play_ptr[w_play_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT: begin
        if (op_done)             w_next = DONE;
        else if (w_wait_expired) w_next = IDLE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    op_store   = (r_state == ISSUE) && r_is_rec;
    op_load    = (r_state == ISSUE) && !r_is_rec;
    busy       = (r_state != IDLE);
    rec_grant  = (r_state == DONE) && r_is_rec;
    play_grant = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      play_grant[i] = (r_state == DONE) && !r_is_rec && (r_op_chan == CHAN_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_rec        <= 1'b0;
      r_op_chan       <= '0;
      r_op_addr       <= '0;
      r_last          <= CHAN_LAST;
      r_rec_ptr       <= '0;
      r_rec_chan_prev <= '0;
      r_rewound       <= 1'b0;
      r_cnt           <= '0;
      r_timeout_err   <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) r_play_ptr[i] <= '0;
    end else begin
      r_rec_chan_prev <= rec_chan;

      if (r_state == IDLE && w_start) begin
        r_is_rec  <= rec_req;
        r_op_chan <= w_sel_chan;
        r_op_addr <= block_addr(32'(w_sel_chan), 32'(w_sel_ptr));
        r_rewound <= 1'b0;
      end else if ((r_state == ISSUE || r_state == WAIT) && rewind) begin
        r_rewound <= 1'b1;
      end

      if (r_state == WAIT) r_cnt <= r_cnt + 1'b1;
      else                 r_cnt <= '0;

      if (w_wait_expired) r_timeout_err <= 1'b1;

      if (rewind || w_rec_chg)    r_rec_ptr <= '0;
      else if (w_do_inc && r_is_rec) r_rec_ptr <= ptr_inc(r_rec_ptr);

      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (rewind)
          r_play_ptr[i] <= '0;
        else if (w_do_inc && !r_is_rec && r_op_chan == CHAN_W'(i))
          r_play_ptr[i] <= ptr_inc(r_play_ptr[i]);
      end

      if (r_state == DONE && !r_is_rec) r_last <= r_op_chan;
    end
  end

  assign op_addr     = r_op_addr;
  assign op_chan     = r_op_chan;
  assign timeout_err = r_timeout_err;

endmodule
